// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the fifo_32 write-port arbiter.
package fifo_write_arbiter_pkg;

  localparam int FIFO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  // One-hot grant vector for a given arbiter state; idle gives 2'b00.
  function automatic logic [1:0] grant_of(arb_state_e s);
    case (s)
      ST_GRANT0: grant_of = 2'b01;
      ST_GRANT1: grant_of = 2'b10;
      default:   grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Two-requester round-robin arbiter for the fifo_32 write port.
// Bounded bursts per grant; the FIFO full flag stalls transfers in the same cycle.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req0Valid,
  input  logic [DATA_WIDTH-1:0] i_req0Data,
  input  logic                  i_req0Last,
  output logic                  o_req0Ready,
  input  logic                  i_req1Valid,
  input  logic [DATA_WIDTH-1:0] i_req1Data,
  input  logic                  i_req1Last,
  output logic                  o_req1Ready,
  input  logic                  i_fifoFull,
  output logic                  o_fifoWriteEnable,
  output logic [DATA_WIDTH-1:0] o_fifoWriteData,
  output logic [1:0]            o_grant
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_served_q, last_served_d; // 1: req1 was served last

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  other_valid;
  logic                  xfer;
  logic                  release_grant;
  logic [CW-1:0]         cnt_inc;

  // Datapath: ready/strobe decode and data mux for the granted requester.
  always_comb begin
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_data    = '0;
    other_valid = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        sel_valid   = i_req0Valid;
        sel_last    = i_req0Last;
        sel_data    = i_req0Data;
        other_valid = i_req1Valid;
      end
      ST_GRANT1: begin
        sel_valid   = i_req1Valid;
        sel_last    = i_req1Last;
        sel_data    = i_req1Data;
        other_valid = i_req0Valid;
      end
      default: ;
    endcase
    o_req0Ready       = (state_q == ST_GRANT0) && !i_fifoFull;
    o_req1Ready       = (state_q == ST_GRANT1) && !i_fifoFull;
    xfer              = sel_valid && (o_req0Ready || o_req1Ready);
    o_fifoWriteEnable = xfer;
    o_fifoWriteData   = xfer ? sel_data : '0;
    o_grant           = grant_of(state_q);
  end

  // Next-state: idle tie-break by last served; release on Last, burst limit or dropped valid.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    release_grant = 1'b0;
    cnt_inc       = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (i_req0Valid && (!i_req1Valid || last_served_q)) state_d = ST_GRANT0;
        else if (i_req1Valid)                                state_d = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        // While full everything is frozen, including the dropped-valid release.
        if (!i_fifoFull) begin
          if (xfer) cnt_d = cnt_inc;
          release_grant = (xfer && (sel_last || cnt_inc == BURST_LIMIT)) || !sel_valid;
          if (release_grant) begin
            cnt_d         = '0;
            last_served_d = (state_q == ST_GRANT1);
            if (other_valid) state_d = (state_q == ST_GRANT0) ? ST_GRANT1 : ST_GRANT0;
            else             state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; req0 wins the first tie after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

endmodule
